// File: rtl/seq_fx_multiplier_if.sv
// Request/response bundle for the sequential fixed-point multiplier:
// start + operands in, busy/valid/ovf + result out.
interface seq_fx_multiplier_if #(
  parameter int unsigned WIDTH = 10
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             valid;
  logic             ovf;
  logic [WIDTH-1:0] result;

  modport master (output start, a_in, b_in, input busy, valid, ovf, result);
  modport slave  (input start, a_in, b_in, output busy, valid, ovf, result);
endinterface

// File: rtl/seq_fx_multiplier.sv
// Sequential shift-add unsigned Q(WIDTH-FRAC).FRAC multiplier, one partial product per cycle.
// Define SEQ_FX_MULT_SATURATE_EN to force result to all-ones on overflow.
module seq_fx_multiplier #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned FRAC  = 6
) (
  input logic                clk,
  input logic                rst_n,
  input logic                sclr,
  seq_fx_multiplier_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ITER, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic [CW-1:0]    count;
  logic             busy_r;
  logic             valid_r;
  logic             ovf_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   q_next;
  logic [2*WIDTH-1:0] prod_next;
  logic               prod_ovf;
  logic [WIDTH-1:0]   prod_out;

  // Add-and-shift for the current step; on the last step the shifted
  // value is already the full product, so outputs load from it directly.
  always_comb begin
    sum       = {carry, acc} + (q[0] ? {1'b0, b_reg} : '0);
    acc_next  = sum[WIDTH:1];
    q_next    = {sum[0], q[WIDTH-1:1]};
    prod_next = {acc_next, q_next};
    prod_ovf  = (prod_next >> (WIDTH + FRAC)) != '0;
`ifdef SEQ_FX_MULT_SATURATE_EN
    prod_out  = prod_ovf ? '1 : WIDTH'(prod_next >> FRAC);
`else
    prod_out  = WIDTH'(prod_next >> FRAC);
`endif
  end

  // Result/valid/ovf are registered on entry to FINISH so they are
  // visible during the FINISH cycle; FINISH itself only retires them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      b_reg    <= '0;
      acc      <= '0;
      q        <= '0;
      carry    <= 1'b0;
      count    <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else if (sclr) begin
      state    <= IDLE;
      b_reg    <= '0;
      acc      <= '0;
      q        <= '0;
      carry    <= 1'b0;
      count    <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= LOAD;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          b_reg <= bus.b_in;
          q     <= bus.a_in;
          acc   <= '0;
          carry <= 1'b0;
          count <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (b_reg == '0 || q == '0) begin
            result_r <= '0;
            valid_r  <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          acc   <= acc_next;
          q     <= q_next;
          carry <= 1'b0;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            result_r <= prod_out;
            valid_r  <= !prod_ovf;
            ovf_r    <= prod_ovf;
            state    <= FINISH;
          end
        end
        FINISH: begin
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          ovf_r   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.ovf    = ovf_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_seq_fx_multiplier.sv
// Bench for seq_fx_multiplier: arithmetic/latency model checked every cycle,
// plus directed operations with hand-computed expected results.
module tb_seq_fx_multiplier;

  localparam int unsigned W = 10;
  localparam int unsigned F = 6;
`ifdef SEQ_FX_MULT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sclr;

  seq_fx_multiplier_if #(.WIDTH(W)) bus ();

  seq_fx_multiplier #(.WIDTH(W), .FRAC(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int t_edge = 0;
  int s_edge = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: product from plain integer arithmetic.
  function automatic int op_lat(input int a, input int b);
    return (a == 0 || b == 0) ? 2 : W + 2;
  endfunction

  function automatic bit op_ovf(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return (p >> (W + F)) != 0;
  endfunction

  function automatic int op_res(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    if (a == 0 || b == 0) return 0;
    if (op_ovf(a, b) && SAT) return (1 << W) - 1;
    return int'((p >> F) % (longint'(1) << W));
  endfunction

  bit m_active = 1'b0;
  int m_k = 0;
  int m_a = 0;
  int m_b = 0;
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  bit m_ovf = 1'b0;
  int m_result = 0;

  always @(posedge clk) t_edge <= t_edge + 1;

  // Edge-indexed model: operands captured one edge after start is taken,
  // outputs land at edge op_lat, idle again one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || sclr) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_ovf    <= 1'b0;
      m_result <= 0;
    end else begin
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
      if (m_active) begin
        m_k <= m_k + 1;
        if (m_k == 0) begin
          m_a <= int'(bus.a_in);
          m_b <= int'(bus.b_in);
        end else if (m_k + 1 == op_lat(m_a, m_b)) begin
          m_result <= op_res(m_a, m_b);
          m_ovf    <= op_ovf(m_a, m_b);
          m_valid  <= !op_ovf(m_a, m_b);
        end else if (m_k == op_lat(m_a, m_b)) begin
          m_active <= 1'b0;
          m_busy   <= 1'b0;
        end
      end else if (bus.start) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_busy   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   int'(bus.busy),   int'(m_busy));
      chk("valid",  int'(bus.valid),  int'(m_valid));
      chk("ovf",    int'(bus.ovf),    int'(m_ovf));
      chk("result", int'(bus.result), m_result);
      chk("valid_ovf_excl", int'(bus.valid & bus.ovf), 0);
    end
  end

  task automatic start_op(input int a, input int b);
    @(negedge clk);
    bus.a_in  = W'(a);
    bus.b_in  = W'(b);
    bus.start = 1'b1;
    s_edge    = t_edge + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_res, input bit exp_ovf, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      if (bus.valid || bus.ovf) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_latency"}, t_edge - s_edge, exp_lat);
      chk({nm, "_result"},  int'(bus.result), exp_res);
      chk({nm, "_ovf"},     int'(bus.ovf), int'(exp_ovf));
      chk({nm, "_valid"},   int'(bus.valid), int'(!exp_ovf));
      @(negedge clk);
      chk({nm, "_busy_drop"},  int'(bus.busy), 0);
      chk({nm, "_pulse_once"}, int'(bus.valid | bus.ovf), 0);
      chk({nm, "_hold"},       int'(bus.result), exp_res);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    sclr      = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",   int'(bus.busy), 0);
    chk("rst_valid",  int'(bus.valid), 0);
    chk("rst_ovf",    int'(bus.ovf), 0);
    chk("rst_result", int'(bus.result), 0);

    // 1.5 * 2.0 = 3.0
    start_op(96, 128);
    chk("busy_after_start", int'(bus.busy), 1);
    wait_done("mul_1p5x2", 192, 1'b0, 12);

    // zero operand early exit
    start_op(0, 700);
    wait_done("zero_a", 0, 1'b0, 2);

    // 8.0 * 4.0 = 32.0 overflows Q4.6
    start_op(512, 256);
    wait_done("ovf_8x4", SAT ? 1023 : 0, 1'b1, 12);

    // smallest lsb squared truncates to zero
    start_op(1, 1);
    wait_done("lsb_sq", 0, 1'b0, 12);

    // 2.5 * 3.25 = 8.125
    start_op(160, 208);
    wait_done("mul_2p5x3p25", 520, 1'b0, 12);

    // async reset mid-operation
    start_op(96, 128);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   int'(bus.busy), 0);
    chk("abort_valid",  int'(bus.valid), 0);
    chk("abort_ovf",    int'(bus.ovf), 0);
    chk("abort_result", int'(bus.result), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_op(96, 128);
    wait_done("after_reset", 192, 1'b0, 12);

    // synchronous clear mid-operation
    start_op(160, 208);
    repeat (3) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    chk("sclr_busy",   int'(bus.busy), 0);
    chk("sclr_result", int'(bus.result), 0);
    repeat (14) @(negedge clk);
    chk("sclr_no_pulse", int'(bus.valid | bus.ovf), 0);

    // second start while busy is ignored; operand changes after load too
    start_op(1023, 1023);
    repeat (2) @(negedge clk);
    bus.a_in  = W'(64);
    bus.b_in  = W'(64);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored_start", SAT ? 1023 : 992, 1'b1, 12);
    repeat (3) @(negedge clk);
    chk("no_queued_op", int'(bus.busy), 0);

    // 1.0 * 1.0 = 1.0
    start_op(64, 64);
    wait_done("mul_1x1", 64, 1'b0, 12);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
